fifo_dac_reader: RTL and testbench
==================================

# fifo_dac_reader

Drain side of the 14-bit sample FIFO: pulls samples at a programmable sample rate and presents them to the DAC data bus. It primes until the FIFO reports more than its almost-empty level, then streams one word per sample tick. It converts two's-complement samples to the DAC's offset-binary code and counts underruns. It sits between the FIFO read port (`rd_en`/`rd_data`/`fifo_empty`/`fifo_almst_empty`) and the DAC pins.

## Interface
- `DATA_WIDTH`, 14, sample and DAC word width.
- `DIV_WIDTH`, 16, width of the sample-rate divider.
- `OFFSET_BINARY`, 1, 1 = invert MSB on output (two's complement to offset binary); 0 = pass through.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  stream enable, level.
- `rate_div`  in  DIV_WIDTH  sample period minus one, in `clk` cycles.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_almst_empty`  in  1  FIFO almost-empty flag.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data, valid one cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO read strobe (combinational).
- `dac_data`  out  DATA_WIDTH  registered DAC code.
- `dac_valid`  out  1  one-cycle pulse when `dac_data` updates.
- `underrun_cnt`  out  8  saturating underrun count.
- `underrun_clr`  in  1  synchronous clear of `underrun_cnt`.
- `busy`  out  1  high in PRIME or RUN.

## Operation
- FSM states are IDLE, PRIME and RUN.
  - IDLE → PRIME when `enable`=1.
  - PRIME → RUN when `fifo_almst_empty`=0 and `enable`=1.
  - RUN → PRIME on underrun.
  - Any state → IDLE when `enable`=0; this has priority over the other transitions.
- Divider:
  - `div_cnt` is cleared to 0 on entry to RUN.
  - In RUN, `tick` = (`div_cnt`==0). On a tick, `div_cnt` loads `rate_div`; otherwise it decrements.
  - `rate_div` is sampled only at reload. `rate_div`=0 gives a tick every cycle.
- Read: `fifo_rd_en` = RUN & `tick` & !`fifo_empty` & `enable`.
- Capture:
  - The cycle after `fifo_rd_en`, `fifo_rd_data` is registered into `dac_data`.
  - The MSB is inverted if `OFFSET_BINARY`=1.
  - `dac_valid` pulses for that same update.
  - A pending capture completes even if the state left RUN or `enable` dropped.
- Underrun:
  - Occurs when RUN & `tick` & `fifo_empty`.
  - No read is issued and `dac_data` holds its previous value.
  - `underrun_cnt` increments, saturating at 255.
  - The state goes to PRIME.
- `underrun_clr`: clears `underrun_cnt` to 0. If it coincides with an underrun, the result is 1.
- `dac_data` holds its value in IDLE and PRIME. The DAC sees the last sample, never garbage.

## Timing
- Reset values:
  - State IDLE, `div_cnt`=0.
  - `fifo_rd_en`=0, `dac_valid`=0, `busy`=0, `underrun_cnt`=0.
  - `dac_data` = midscale: 0x2000 when `OFFSET_BINARY`=1, else 0x0000.
- `enable` rises in cycle E → PRIME in E+1. RUN is entered the cycle after PRIME sees `fifo_almst_empty`=0.
- First RUN cycle T has `tick`, so `fifo_rd_en`=1 in T if the FIFO is non-empty.
- The data registers at the end of T+1. `dac_data`/`dac_valid` are visible in T+2.
- Latency from `fifo_rd_en` to `dac_valid` is 2 cycles.
- Sample period is `rate_div`+1 cycles. Back-to-back reads are legal when `rate_div`=0.
- `enable` low in RUN cycle X → IDLE in X+1. No `fifo_rd_en` in X. A read issued in X-1 still produces `dac_valid` in X+1.
- `rst` asserted mid-stream returns all outputs to reset values immediately (async). Any in-flight capture is discarded.

## Test plan
- Reset/idle: hold `rst` then release with `enable`=0 → `dac_data`=0x2000, `fifo_rd_en` never asserts, `busy`=0.
- Prime and stream: preload 16 words 0..15, `rate_div`=3, raise `enable`.
  - `fifo_rd_en` asserts once every 4 cycles.
  - `dac_data` sequence is 0x2000, 0x2001, … 0x200F.
  - Each `dac_valid` occurs exactly 2 cycles after its read.
- Conversion: FIFO word 0x3FFF (-1) with `OFFSET_BINARY`=1 → `dac_data`=0x1FFF. Word 0x2000 (min) → 0x0000.
- Underrun: stream 3 words with `rate_div`=0 and no refill.
  - Fourth tick sees `fifo_empty` → no read, `underrun_cnt`=1, state PRIME.
  - `dac_data` holds 3rd value.
  - 300 forced underruns saturate the count at 255. `underrun_clr` coincident with an underrun gives 1.
- Disable mid-stream: drop `enable` the cycle after a read → that sample's `dac_valid` still appears. No further reads. IDLE next cycle.
- Async reset mid-stream: assert `rst` between read and capture → no `dac_valid`, `dac_data`=0x2000 immediately, FSM IDLE.

Source files
------------

// File: rtl/fifo_dac_reader.sv
// FIFO drain to DAC: primes on almost-empty, then reads one sample per
// divider tick, converts to offset binary and counts underruns.
module fifo_dac_reader #(
  parameter int DATA_WIDTH    = 14,
  parameter int DIV_WIDTH     = 16,
  parameter int OFFSET_BINARY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic                  fifo_empty,
  input  logic                  fifo_almst_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_valid,
  output logic [7:0]            underrun_cnt,
  input  logic                  underrun_clr,
  output logic                  busy
);

  // XOR mask doubles as the midscale code shown after reset
  localparam logic [DATA_WIDTH-1:0] MSB_MASK =
    (OFFSET_BINARY != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                         : {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic                  r_busy;
  logic                  r_rd_pend;
  logic                  r_dac_valid;
  logic [DATA_WIDTH-1:0] r_dac_data;
  logic [7:0]            r_urun_cnt;

  logic w_tick;
  logic w_go;
  logic w_underrun;

  assign w_tick     = (r_state == RUN) && (r_div_cnt == '0);
  assign w_go       = w_tick && enable;
  assign w_underrun = w_go && fifo_empty;

  assign fifo_rd_en   = w_go && !fifo_empty;
  assign dac_data     = r_dac_data;
  assign dac_valid    = r_dac_valid;
  assign underrun_cnt = r_urun_cnt;
  assign busy         = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= PRIME;
            r_busy  <= 1'b1;
          end
        end
        PRIME: begin
          if (!enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (!fifo_almst_empty) begin
            r_state   <= RUN;
            r_div_cnt <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_underrun) begin
            r_state <= PRIME;
          end else if (w_tick) begin
            r_div_cnt <= rate_div;
          end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Capture lands one cycle after the read, regardless of state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend   <= 1'b0;
      r_dac_valid <= 1'b0;
      r_dac_data  <= MSB_MASK;
    end else begin
      r_rd_pend   <= fifo_rd_en;
      r_dac_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_dac_data <= fifo_rd_data ^ MSB_MASK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_urun_cnt <= 8'd0;
    end else if (underrun_clr) begin
      r_urun_cnt <= w_underrun ? 8'd1 : 8'd0;
    end else if (w_underrun && (r_urun_cnt != 8'hFF)) begin
      r_urun_cnt <= r_urun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_dac_reader.sv
// Directed bench for fifo_dac_reader with a small registered-read FIFO
// model; almost-empty asserts at two words or fewer.
module tb_fifo_dac_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] rate_div = 16'd0;
  logic        fifo_empty;
  logic        fifo_almst_empty;
  logic [13:0] fifo_rd_data = 14'd0;
  logic        fifo_rd_en;
  logic [13:0] dac_data;
  logic        dac_valid;
  logic [7:0]  underrun_cnt;
  logic        underrun_clr = 1'b0;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [13:0] mem [0:511];
  logic [8:0]  wr_ptr = 9'd0;
  logic [8:0]  rd_ptr = 9'd0;
  logic [8:0]  fcnt;
  logic        force_starve = 1'b0;

  assign fcnt = wr_ptr - rd_ptr;
  assign fifo_empty = force_starve | (fcnt == 9'd0);
  assign fifo_almst_empty = force_starve ? 1'b0 : (fcnt <= 9'd2);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 9'd1;
    end
  end

  fifo_dac_reader dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .rate_div(rate_div),
    .fifo_empty(fifo_empty),
    .fifo_almst_empty(fifo_almst_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en),
    .dac_data(dac_data),
    .dac_valid(dac_valid),
    .underrun_cnt(underrun_cnt),
    .underrun_clr(underrun_clr),
    .busy(busy)
  );

  task automatic push(input logic [13:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 9'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    underrun_clr = 1'b0;
    force_starve = 1'b0;
    wr_ptr = rd_ptr;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int nrd;
    int nbusy;
    do_reset();
    for (int k = 0; k < 8; k++) push(14'(k + 1));
    nrd = 0;
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (busy) nbusy++;
    end
    tests_run++;
    if (dac_data !== 14'h2000) begin
      tests_failed++;
      $display("FAIL reset_dac_data: got %0h want 2000", dac_data);
    end
    tests_run++;
    if (dac_valid !== 1'b0 || underrun_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_valid_cnt: got %0b/%0d want 0/0",
               dac_valid, underrun_cnt);
    end
    tests_run++;
    if (nrd != 0 || nbusy != 0) begin
      tests_failed++;
      $display("FAIL idle_no_read_busy: got rd=%0d busy=%0d want 0/0",
               nrd, nbusy);
    end
  endtask

  task automatic test_stream();
    int rd_t [0:31];
    int nr;
    int nv;
    int bad;
    int et;
    do_reset();
    rate_div = 16'd3;
    for (int k = 0; k < 16; k++) push(14'(k));
    @(negedge clk);
    enable = 1'b1;
    nr = 0;
    nv = 0;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (i == 1) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL prime_busy: got %0b want 1", busy);
        end
      end
      if (fifo_rd_en) begin
        if (nr < 32) rd_t[nr] = i;
        nr++;
      end
      if (dac_valid) begin
        et = (nv < nr && nv < 32) ? rd_t[nv] + 2 : -1;
        tests_run++;
        if (i != et || dac_data !== (14'h2000 | 14'(nv))) begin
          tests_failed++;
          $display("FAIL stream_sample%0d: got cyc=%0d data=%0h want cyc=%0d data=%0h",
                   nv, i, dac_data, et, 14'h2000 | 14'(nv));
        end
        nv++;
      end
    end
    bad = 0;
    for (int k = 0; k < 15 && k + 1 < nr; k++)
      if (rd_t[k+1] - rd_t[k] != 4) bad++;
    tests_run++;
    if (nr != 16 || nv != 16 || bad != 0) begin
      tests_failed++;
      $display("FAIL stream_count: got rd=%0d val=%0d badgap=%0d want 16/16/0",
               nr, nv, bad);
    end
    tests_run++;
    if (nr < 1 || rd_t[0] != 2) begin
      tests_failed++;
      $display("FAIL first_read_cycle: got %0d want 2", nr > 0 ? rd_t[0] : -1);
    end
    tests_run++;
    if (underrun_cnt !== 8'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_drain_underrun: got cnt=%0d busy=%0b want 1/1",
               underrun_cnt, busy);
    end
    enable = 1'b0;
  endtask

  task automatic test_conversion();
    logic [13:0] exp_v [0:3];
    int nv;
    exp_v[0] = 14'h1FFF;
    exp_v[1] = 14'h0000;
    exp_v[2] = 14'h3FFF;
    exp_v[3] = 14'h2000;
    do_reset();
    rate_div = 16'd0;
    push(14'h3FFF);
    push(14'h2000);
    push(14'h1FFF);
    push(14'h0000);
    @(negedge clk);
    enable = 1'b1;
    nv = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (dac_valid) begin
        tests_run++;
        if (nv > 3 || dac_data !== exp_v[nv & 3]) begin
          tests_failed++;
          $display("FAIL convert%0d: got %0h want %0h",
                   nv, dac_data, exp_v[nv & 3]);
        end
        nv++;
      end
    end
    tests_run++;
    if (nv != 4) begin
      tests_failed++;
      $display("FAIL convert_count: got %0d want 4", nv);
    end
    enable = 1'b0;
  endtask

  task automatic test_underrun();
    int nr;
    do_reset();
    rate_div = 16'd0;
    push(14'h0005);
    push(14'h0006);
    push(14'h0007);
    @(negedge clk);
    enable = 1'b1;
    nr = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (fifo_rd_en) nr++;
    end
    tests_run++;
    if (nr != 3 || underrun_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL underrun_basic: got rd=%0d cnt=%0d want 3/1",
               nr, underrun_cnt);
    end
    tests_run++;
    if (dac_data !== 14'h2007 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun_hold: got data=%0h busy=%0b want 2007/1",
               dac_data, busy);
    end
    push(14'h0009);
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_rd_en) nr++;
    end
    tests_run++;
    if (nr != 0) begin
      tests_failed++;
      $display("FAIL prime_waits: got rd=%0d want 0", nr);
    end
    push(14'h000A);
    push(14'h000B);
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) nr++;
    end
    tests_run++;
    if (nr != 3) begin
      tests_failed++;
      $display("FAIL rerun_after_prime: got rd=%0d want 3", nr);
    end
    enable = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    rate_div = 16'd0;
    force_starve = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 620; i++) @(negedge clk);
    tests_run++;
    if (underrun_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL saturate: got %0d want 255", underrun_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    tests_run++;
    if (underrun_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL clr_coincident: got %0d want 1", underrun_cnt);
    end
    @(negedge clk);
    underrun_clr = 1'b0;
    tests_run++;
    if (underrun_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL clr_plain: got %0d want 0", underrun_cnt);
    end
    @(negedge clk);
    tests_run++;
    if (underrun_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL count_after_clr: got %0d want 1", underrun_cnt);
    end
    enable = 1'b0;
    force_starve = 1'b0;
  endtask

  task automatic test_disable();
    int nr;
    do_reset();
    rate_div = 16'd0;
    for (int k = 0; k < 8; k++) push(14'h10 + 14'(k));
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (fifo_rd_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL disable_pre_read: got %0b want 1", fifo_rd_en);
    end
    @(negedge clk);
    enable = 1'b0;
    #1;
    tests_run++;
    if (fifo_rd_en !== 1'b0 || dac_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable_cycle_x: got rd=%0b val=%0b want 0/0",
               fifo_rd_en, dac_valid);
    end
    @(negedge clk);
    tests_run++;
    if (dac_valid !== 1'b1 || dac_data !== 14'h2010 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable_capture: got val=%0b data=%0h busy=%0b want 1/2010/0",
               dac_valid, dac_data, busy);
    end
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en || dac_valid) nr++;
    end
    tests_run++;
    if (nr != 0 || dac_data !== 14'h2010) begin
      tests_failed++;
      $display("FAIL disable_quiet: got events=%0d data=%0h want 0/2010",
               nr, dac_data);
    end
  endtask

  task automatic test_async_reset();
    int nv;
    do_reset();
    rate_div = 16'd0;
    for (int k = 0; k < 8; k++) push(14'h10 + 14'(k));
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) @(negedge clk);
    tests_run++;
    if (dac_data !== 14'h2012 || fifo_rd_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: got data=%0h rd=%0b want 2012/1",
               dac_data, fifo_rd_en);
    end
    rst = 1'b1;
    enable = 1'b0;
    #1;
    tests_run++;
    if (dac_data !== 14'h2000 || dac_valid !== 1'b0 ||
        busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_now: got data=%0h val=%0b busy=%0b rd=%0b want 2000/0/0/0",
               dac_data, dac_valid, busy, fifo_rd_en);
    end
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dac_valid || busy) nv++;
    end
    tests_run++;
    if (nv != 0 || dac_data !== 14'h2000) begin
      tests_failed++;
      $display("FAIL areset_after: got events=%0d data=%0h want 0/2000",
               nv, dac_data);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_conversion();
    test_underrun();
    test_saturate();
    test_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
